// File: rtl/receiver_uart_pkg.sv
// Shared types for the 8N1 UART receiver.
package receiver_uart_pkg;

    typedef enum logic [1:0] {
        UART_RX_IDLE  = 2'd0,
        UART_RX_START = 2'd1,
        UART_RX_DATA  = 2'd2,
        UART_RX_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/fifo_sync.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers.
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_empty,
    output logic             o_full,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             do_push;
    logic             do_pop;

    assign o_count = CW'(wr_q - rd_q);
    assign o_empty = (wr_q == rd_q);
    assign o_full  = (o_count == CW'(DEPTH));
    assign o_dout  = o_empty ? '0 : mem_q[rd_q[AW-1:0]];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = i_push && (!o_full || i_pop);
    assign do_pop  = i_pop && !o_empty;
    assign wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    assign rd_d    = do_pop ? rd_q + 1'b1 : rd_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= i_din;
        end
    end

endmodule

// File: rtl/receiver_uart.sv
// 8N1 UART receiver: RX synchronizer, mid-bit sampling FSM,
// receive FIFO and sticky overrun / framing error flags.
module receiver_uart
    import receiver_uart_pkg::*;
#(
    parameter int clk_freq_hz = 12000000,
    parameter int baud_rate   = 115200,
    parameter int fifo_depth  = 4,
    localparam int CW = $clog2(fifo_depth + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_uart_rx,
    input  logic          i_pop,
    input  logic          i_clr_err,
    output logic [7:0]    o_data,
    output logic          o_valid,
    output logic [CW-1:0] o_count,
    output logic          o_overrun,
    output logic          o_frame_err
);

    localparam int CPB   = clk_freq_hz / baud_rate;
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = $clog2(CPB);

    logic             sync_q;
    logic             rx_s_q;
    rx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;
    logic             stop_tick;
    logic             push;
    logic             ferr_set;
    logic             ovr_set;
    logic             fifo_empty;
    logic             fifo_full;

    assign stop_tick = (state_q == UART_RX_STOP) && (cnt_q == CNT_W'(CPB - 1));
    assign push      = stop_tick && rx_s_q;
    assign ferr_set  = stop_tick && !rx_s_q;
    assign ovr_set   = push && fifo_full && !i_pop;

    // A new error event takes priority over a simultaneous clear.
    assign overrun_d   = ovr_set || (overrun_q && !i_clr_err);
    assign frame_err_d = ferr_set || (frame_err_q && !i_clr_err);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= 1'b1;
            rx_s_q <= 1'b1;
        end else begin
            sync_q <= i_uart_rx;
            rx_s_q <= sync_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= UART_RX_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            unique case (state_q)
                UART_RX_IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= UART_RX_START;
                        cnt_q   <= '0;
                    end
                end
                UART_RX_START: begin
                    if (cnt_q == CNT_W'(HALF - 1)) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= rx_s_q ? UART_RX_IDLE : UART_RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                UART_RX_DATA: begin
                    if (cnt_q == CNT_W'(CPB - 1)) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s_q, shift_q[7:1]};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == 3'd7) begin
                            state_q <= UART_RX_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                UART_RX_STOP: begin
                    if (stop_tick) begin
                        cnt_q   <= '0;
                        state_q <= UART_RX_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= UART_RX_IDLE;
            endcase
        end
    end

    fifo_sync #(
        .WIDTH (8),
        .DEPTH (fifo_depth)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_pop   (i_pop),
        .i_din   (shift_q),
        .o_dout  (o_data),
        .o_empty (fifo_empty),
        .o_full  (fifo_full),
        .o_count (o_count)
    );

    assign o_valid     = !fifo_empty;
    assign o_overrun   = overrun_q;
    assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_receiver_uart.sv
// Self-checking bench for receiver_uart: vector table, corner sequences
// and randomized frames against a queue-based reference model.
module tb_receiver_uart;

    localparam int CPB   = 104;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       pop = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] o_data;
    logic       o_valid;
    logic [2:0] o_count;
    logic       o_overrun;
    logic       o_frame_err;

    int checks = 0;
    int errors = 0;

    bit [7:0] mq[$];
    bit       m_ovr;
    bit       m_fe;

    typedef struct {
        logic [7:0] d;
        bit         ok;
        int         exp_cnt;
        logic [7:0] exp_head;
        bit         exp_ovr;
        bit         exp_fe;
    } vec_t;

    vec_t tbl[6];

    receiver_uart dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_uart_rx   (rx),
        .i_pop       (pop),
        .i_clr_err   (clr),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_count     (o_count),
        .o_overrun   (o_overrun),
        .o_frame_err (o_frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mq.delete();
        m_ovr = 1'b0;
        m_fe = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_ok);
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = d[i];
            repeat (CPB) @(posedge clk);
        end
        #1 rx = stop_ok;
        if (stop_ok) begin
            repeat (CPB) @(posedge clk);
        end else begin
            repeat (60) @(posedge clk);
            #1 rx = 1'b1;
            repeat (CPB - 60) @(posedge clk);
        end
        #1 rx = 1'b1;
    endtask

    task automatic do_pop();
        @(posedge clk);
        #1 pop = 1'b1;
        @(posedge clk);
        #1 pop = 1'b0;
    endtask

    task automatic do_clr();
        @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
    endtask

    function automatic void model_frame(input bit [7:0] d, input bit ok);
        if (!ok) m_fe = 1'b1;
        else if (mq.size() == DEPTH) m_ovr = 1'b1;
        else mq.push_back(d);
    endfunction

    task automatic check_model(input string tag);
        @(negedge clk);
        chk({tag, "_count"}, int'(o_count), mq.size());
        chk({tag, "_valid"}, int'(o_valid), int'(mq.size() != 0));
        if (mq.size() != 0) chk({tag, "_data"}, int'(o_data), int'(mq[0]));
        chk({tag, "_ovr"}, int'(o_overrun), int'(m_ovr));
        chk({tag, "_fe"}, int'(o_frame_err), int'(m_fe));
    endtask

    initial begin
        int cyc;
        logic [7:0] rd;

        tbl[0] = '{8'h3C, 1'b0, 0, 8'h00, 1'b0, 1'b1};
        tbl[1] = '{8'h01, 1'b1, 1, 8'h01, 1'b0, 1'b1};
        tbl[2] = '{8'h02, 1'b1, 2, 8'h01, 1'b0, 1'b1};
        tbl[3] = '{8'h03, 1'b1, 3, 8'h01, 1'b0, 1'b1};
        tbl[4] = '{8'h04, 1'b1, 4, 8'h01, 1'b0, 1'b1};
        tbl[5] = '{8'h05, 1'b1, 4, 8'h01, 1'b1, 1'b1};

        do_reset();
        @(negedge clk);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_count", int'(o_count), 0);
        chk("rst_data", int'(o_data), 0);
        chk("rst_ovr", int'(o_overrun), 0);
        chk("rst_fe", int'(o_frame_err), 0);

        // back-to-back 0x55 / 0xA3 with first-byte latency
        cyc = 0;
        fork
            begin
                send_frame(8'h55, 1'b1);
                send_frame(8'hA3, 1'b1);
            end
            begin
                @(posedge clk);
                while (cyc < 3000) begin
                    @(negedge clk);
                    cyc++;
                    if (o_valid) break;
                end
            end
        join
        checks++;
        if (cyc < 985 || cyc > 1000) begin
            errors++;
            $display("FAIL b2b_latency: got %0d cycles expected 985..1000", cyc);
        end
        @(negedge clk);
        chk("b2b_head0", int'(o_data), 'h55);
        chk("b2b_count", int'(o_count), 2);
        do_pop();
        @(negedge clk);
        chk("b2b_head1", int'(o_data), 'hA3);
        do_pop();
        @(negedge clk);
        chk("b2b_empty", int'(o_valid), 0);
        chk("b2b_flags", int'({o_overrun, o_frame_err}), 0);

        // table: bad stop, then fill past depth
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i].d, tbl[i].ok);
            @(negedge clk);
            chk($sformatf("tbl%0d_count", i), int'(o_count), tbl[i].exp_cnt);
            chk($sformatf("tbl%0d_valid", i), int'(o_valid),
                int'(tbl[i].exp_cnt != 0));
            if (tbl[i].exp_cnt != 0)
                chk($sformatf("tbl%0d_head", i), int'(o_data), int'(tbl[i].exp_head));
            chk($sformatf("tbl%0d_ovr", i), int'(o_overrun), int'(tbl[i].exp_ovr));
            chk($sformatf("tbl%0d_fe", i), int'(o_frame_err), int'(tbl[i].exp_fe));
        end
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("drain%0d", i), int'(o_data), i);
            do_pop();
        end
        @(negedge clk);
        chk("drain_empty", int'(o_valid), 0);
        do_pop();
        @(negedge clk);
        chk("pop_empty_count", int'(o_count), 0);
        do_clr();
        @(negedge clk);
        chk("clr_flags", int'({o_overrun, o_frame_err}), 0);

        // short low glitch, then a good frame
        do_reset();
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (20) @(posedge clk);
        #1 rx = 1'b1;
        repeat (300) @(posedge clk);
        @(negedge clk);
        chk("glitch_count", int'(o_count), 0);
        chk("glitch_flags", int'({o_overrun, o_frame_err}), 0);
        send_frame(8'h7E, 1'b1);
        model_frame(8'h7E, 1'b1);
        check_model("glitch_after");

        // pop in the exact cycle a push lands on a full FIFO
        do_reset();
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
        fork
            send_frame(8'h99, 1'b1);
            begin
                @(posedge clk);
                repeat (990) @(posedge clk);
                #1 pop = 1'b1;
                @(posedge clk);
                #1 pop = 1'b0;
            end
        join
        @(negedge clk);
        chk("pushpop_count", int'(o_count), 4);
        chk("pushpop_ovr", int'(o_overrun), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rd = (i == 3) ? 8'h99 : 8'(i + 2);
            chk($sformatf("pushpop_q%0d", i), int'(o_data), int'(rd));
            do_pop();
        end

        // reset during bit 4 of a frame
        do_reset();
        rd = 8'h5A;
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            #1 rx = rd[i];
            repeat ((i == 4) ? CPB / 2 : CPB) @(posedge clk);
        end
        do_reset();
        repeat (200) @(posedge clk);
        send_frame(8'hC3, 1'b1);
        model_frame(8'hC3, 1'b1);
        check_model("midrst");

        // randomized frames against the model
        do_reset();
        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            bit ok;
            int np;
            d = 8'($urandom);
            ok = ($urandom_range(0, 5) != 0);
            send_frame(d, ok);
            model_frame(d, ok);
            np = $urandom_range(0, 2);
            for (int p = 0; p < np; p++) begin
                do_pop();
                if (mq.size() != 0) void'(mq.pop_front());
            end
            if ($urandom_range(0, 5) == 0) begin
                do_clr();
                m_ovr = 1'b0;
                m_fe = 1'b0;
            end
            repeat ($urandom_range(0, 30)) @(posedge clk);
            check_model($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/receiver_uart.md
Name: receiver_uart

Overview:
- 8N1 UART receiver for the icesugar SoC. Consumes the board RX pin, which is currently unused, and feeds received bytes to the CPU through the memory-mapped IO block.
- Sits beside emitter_uart.
- Provides the mid-bit sampling FSM, a small first-word-fall-through receive FIFO, and sticky error flags. IO decode exposes these as data and status words.

Parameters:
- clk_freq_hz, 12000000: system clock frequency in Hz.
- baud_rate, 115200: line rate. CLKS_PER_BIT = clk_freq_hz / baud_rate, integer division, giving 104 at the defaults.
- fifo_depth, 4: receive FIFO entries. Must be a power of two and at least 2.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_uart_rx  in  1  asynchronous serial input; idles high.
- i_pop  in  1  dequeue the head byte; single-cycle strobe.
- i_clr_err  in  1  clear both sticky error flags.
- o_data  out  8  FIFO head byte; valid while o_valid is high.
- o_valid  out  1  FIFO non-empty.
- o_count  out  $clog2(fifo_depth+1)  FIFO occupancy.
- o_overrun  out  1  sticky: a good byte was dropped because the FIFO was full.
- o_frame_err  out  1  sticky: a stop bit was sampled low.

Behaviour:
- Reset values, synchronous on i_rst: synchronizer flops = 1; FSM = IDLE; bit and clock counters = 0; FIFO empty (o_valid = 0, o_count = 0, o_data = 0); o_overrun = 0; o_frame_err = 0.
- Reset asserted mid-frame abandons the partial byte. No push occurs and no flag is set.
- Input: two-flop synchronizer producing rx_s. All FSM decisions use rx_s only.
- Clock counter runs 0..CLKS_PER_BIT-1. HALF = CLKS_PER_BIT/2 = 52.
- IDLE: on rx_s = 0, go to START and clear the counter.
- START: when the counter reaches HALF-1, sample rx_s.
  - rx_s = 0: go to DATA and clear the counter and bit index.
  - rx_s = 1: treat as a glitch and return to IDLE. No flag is set.
- DATA: when the counter reaches CLKS_PER_BIT-1, shift rx_s into the shift register LSB first and clear the counter. After bit index 7, go to STOP.
- STOP: when the counter reaches CLKS_PER_BIT-1, sample rx_s and then return to IDLE.
  - rx_s = 1: push the byte.
  - rx_s = 0: set o_frame_err and discard the byte.
  - Returning to IDLE at mid-stop allows back-to-back frames with a single stop bit.
- Latency: a pushed byte is visible as o_valid = 1 with o_data set on the cycle after the stop-bit sample.
- FIFO is first-word-fall-through. o_data always presents the head entry. Read and write pointers are $clog2(fifo_depth)+1 bits wide and wrap naturally.
- i_pop while empty is ignored. Pointers and o_count are unchanged.
- Push while full and no pop in the same cycle: byte dropped, o_overrun set, existing contents unchanged.
- Push and pop in the same cycle while full: both take effect, o_count stays at fifo_depth, o_overrun not set.
- Push and pop in the same cycle while non-empty: o_count unchanged.
- i_clr_err clears both flags. If an error event occurs in the same cycle as i_clr_err, the set wins.
- No parity support and no break detection. A line held low re-enters START after each frame and flags o_frame_err.

Decomposition:
- Add to the shared inc/define.vh: the FSM state encodings (UART_RX_IDLE, UART_RX_START, UART_RX_DATA, UART_RX_STOP; 2 bits) and the IO bit index for the RX data and status words.
- The synchronizer and FSM live in receiver_uart.
- The FIFO is a natural sub-module, fifo_sync, parameterised by width and depth. Its ports are push, pop, din, dout, empty, full and count, with the same synchronous active-high reset.

Test Plan:
- 0x55 and then 0xA3 at 104 clk/bit, 1 stop bit, back-to-back -> o_valid rises about 990 cycles after the first falling edge. o_data = 0x55; after i_pop, o_data = 0xA3; after a second pop, o_valid = 0 and no error flags.
- 5 frames (0x01..0x05) with no pops, depth 4 -> o_count = 4, o_overrun = 1. Popping yields 0x01..0x04, then o_valid = 0.
- Frame 0x3C with the stop bit driven low -> no push (o_count = 0), o_frame_err = 1. A pulse on i_clr_err brings it to 0.
- 20-cycle low glitch on RX -> FSM returns to IDLE. No push, no flags. A following valid 0x7E is received correctly.
- FIFO full; assert i_pop in the exact cycle a 5th byte 0x99 is pushed -> o_count stays 4, o_overrun = 0, 0x99 is at the tail.
- Assert i_rst during bit 4 of a frame, release, then send 0xC3 -> only 0xC3 received; o_count = 1, flags 0.
